// File: rtl/nas_vid_capture_if.sv
// Capture-side bundle: composite video in, frame-buffer write port and status out.
interface nas_vid_capture_if #(
    parameter int ADDR_W = 14
);
    logic              vid_sync;
    logic              vid_data;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic [8:0]        line_no;
    logic              frame_done;
    logic              err_short;
    logic              err_frame;

    // master: the capture block, which owns the frame-buffer write port
    modport master (
        input  vid_sync, vid_data,
        output fb_we, fb_addr, fb_data, line_no, frame_done, err_short, err_frame
    );

    modport slave (
        output vid_sync, vid_data,
        input  fb_we, fb_addr, fb_data, line_no, frame_done, err_short, err_frame
    );
endinterface

// File: rtl/nas_vid_capture.sv
// Composite video capture: classifies sync pulses by width, recovers dots at DOT_DIV
// clocks per dot and writes packed bytes into a frame-buffer port.
module nas_vid_capture #(
    parameter int DOT_DIV = 2,
    parameter int VS_MIN  = 320,
    parameter int H_BACK  = 200,
    parameter int H_BYTES = 48,
    parameter int V_BACK  = 16,
    parameter int V_LINES = 256,
    parameter int ADDR_W  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    nas_vid_capture_if.master   vif
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_VS = 3'd1;
    localparam logic [2:0] S_VBACK   = 3'd2;
    localparam logic [2:0] S_WAIT_HS = 3'd3;
    localparam logic [2:0] S_HDELAY  = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;

    localparam int PW = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
    localparam int HW = $clog2(H_BACK + 1);
    localparam int IW = (H_BYTES > 1) ? $clog2(H_BYTES) : 1;
    localparam int VW = $clog2(V_BACK + 1);
    localparam logic [9:0] VS_SAT = 10'(VS_MIN);

    logic [1:0]        sync_sq, data_sq;
    logic              sync_prev_q;
    logic [9:0]        scnt_q;
    logic              sync_s, data_s, sync_fall, sync_rise, vs_evt, hs_evt;

    logic [2:0]        state_q, state_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [2:0]        dot_q, dot_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [8:0]        line_q, line_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        shift_q, shift_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        fb_data_q, fb_data_d;
    logic              done_q, done_d;
    logic              err_short_q, err_short_d;
    logic              err_frame_q, err_frame_d;
    logic              line_end;

    assign sync_s    = sync_sq[1];
    assign data_s    = data_sq[1];
    assign sync_fall = sync_prev_q & ~sync_s;
    assign sync_rise = ~sync_prev_q & sync_s;
    assign vs_evt    = sync_rise & (scnt_q >= VS_SAT);
    assign hs_evt    = sync_rise & (scnt_q <  VS_SAT);

    // The falling-edge cycle is already the first low clock, so the count restarts at 1;
    // a pulse of exactly VS_MIN low clocks then reads VS_MIN on its rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_sq     <= 2'b11;
            data_sq     <= 2'b11;
            sync_prev_q <= 1'b1;
            scnt_q      <= '0;
        end else begin
            sync_sq     <= {sync_sq[0], vif.vid_sync};
            data_sq     <= {data_sq[0], vif.vid_data};
            sync_prev_q <= sync_s;
            if (sync_fall)
                scnt_q <= 10'd1;
            else if (!sync_s && scnt_q < VS_SAT)
                scnt_q <= scnt_q + 10'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        phase_d     = phase_q;
        dot_d       = dot_q;
        idx_d       = idx_q;
        line_d      = line_q;
        base_d      = base_q;
        shift_d     = shift_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        done_d      = 1'b0;
        err_short_d = err_short_q;
        err_frame_d = err_frame_q;
        line_end    = 1'b0;

        case (state_q)
            S_IDLE: if (en) state_d = S_WAIT_VS;
            S_WAIT_VS: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (vs_evt) begin
                    state_d = S_VBACK;
                    line_d  = '0;
                    base_d  = '0;
                    vcnt_d  = '0;
                end
            end
            S_VBACK: begin
                if (hs_evt) begin
                    if (vcnt_q == VW'(V_BACK - 1)) begin
                        state_d = S_HDELAY;
                        hcnt_d  = '0;
                    end else begin
                        vcnt_d = vcnt_q + VW'(1);
                    end
                end
            end
            S_WAIT_HS: begin
                if (hs_evt) begin
                    state_d = S_HDELAY;
                    hcnt_d  = '0;
                end
            end
            S_HDELAY: begin
                if (hcnt_q == HW'(H_BACK - 1)) begin
                    state_d = S_CAPTURE;
                    phase_d = '0;
                    dot_d   = '0;
                    idx_d   = '0;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            S_CAPTURE: begin
                if (sync_fall) begin
                    // line cut short: partial byte is discarded, line still counts
                    err_short_d = 1'b1;
                    line_end    = 1'b1;
                end else begin
                    if (phase_q == '0)
                        shift_d = {shift_q[6:0], data_s};
                    if (phase_q == PW'(DOT_DIV - 1)) begin
                        phase_d = '0;
                        dot_d   = dot_q + 3'd1;
                        if (dot_q == 3'd7) begin
                            fb_we_d   = 1'b1;
                            fb_data_d = shift_d;
                            fb_addr_d = base_q + ADDR_W'(idx_q);
                            if (idx_q == IW'(H_BYTES - 1))
                                line_end = 1'b1;
                            else
                                idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (line_end) begin
            idx_d   = '0;
            dot_d   = '0;
            phase_d = '0;
            if (line_q == 9'(V_LINES - 1)) begin
                line_d  = '0;
                base_d  = '0;
                done_d  = 1'b1;
                state_d = S_WAIT_VS;
            end else begin
                line_d  = line_q + 9'd1;
                base_d  = base_q + ADDR_W'(H_BYTES);
                state_d = S_WAIT_HS;
            end
        end

        // A vsync anywhere inside a frame abandons it and restarts the vertical count.
        if (vs_evt && (state_q inside {S_VBACK, S_WAIT_HS, S_HDELAY, S_CAPTURE})) begin
            err_frame_d = 1'b1;
            state_d     = S_VBACK;
            line_d      = '0;
            base_d      = '0;
            vcnt_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            phase_q     <= '0;
            dot_q       <= '0;
            idx_q       <= '0;
            line_q      <= '0;
            base_q      <= '0;
            shift_q     <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            done_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            phase_q     <= phase_d;
            dot_q       <= dot_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            base_q      <= base_d;
            shift_q     <= shift_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            done_q      <= done_d;
            err_short_q <= err_short_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign vif.fb_we      = fb_we_q;
    assign vif.fb_addr    = fb_addr_q;
    assign vif.fb_data    = fb_data_q;
    assign vif.line_no    = line_q;
    assign vif.frame_done = done_q;
    assign vif.err_short  = err_short_q;
    assign vif.err_frame  = err_frame_q;
endmodule

// File: tb/tb_nas_vid_capture.sv
// Directed bench for nas_vid_capture with a scaled-down raster so whole frames stay short.
module tb_nas_vid_capture;
    localparam int DOT_DIV = 2;
    localparam int VS_MIN  = 40;
    localparam int H_BACK  = 20;
    localparam int H_BYTES = 4;
    localparam int V_BACK  = 3;
    localparam int V_LINES = 6;
    localparam int ADDR_W  = 8;
    localparam int HS_LEN  = 8;
    localparam int VS_LEN  = 50;
    localparam int LINE_T  = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   fd_cnt = 0;
    int   wa[$];
    logic [7:0] wd[$];

    nas_vid_capture_if #(.ADDR_W(ADDR_W)) vif ();

    nas_vid_capture #(
        .DOT_DIV(DOT_DIV), .VS_MIN(VS_MIN), .H_BACK(H_BACK), .H_BYTES(H_BYTES),
        .V_BACK(V_BACK), .V_LINES(V_LINES), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .vif(vif)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (vif.fb_we) begin
                wa.push_back(int'(vif.fb_addr));
                wd.push_back(vif.fb_data);
            end
            if (vif.frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input int l, input int b);
        logic [7:0] v;
        v = 8'(l * 37 + b * 91);
        return (b == 0) ? 8'hA5 : (v ^ 8'h5A);
    endfunction

    // m counts clocks after sync rises; the raw dot k must be present at edge 2+H_BACK+k*DOT_DIV
    function automatic logic dot_val(input int l, input int m);
        int idx, dot;
        logic [7:0] b;
        idx = m - 2 - H_BACK;
        if (l < 0 || idx < 0 || idx >= 8 * H_BYTES * DOT_DIV) return 1'b0;
        dot = idx / DOT_DIV;
        b   = exp_byte(l, dot / 8);
        return b[7 - dot % 8];
    endfunction

    task automatic send_line(input int l, input int cut);
        vif.vid_sync = 1'b0;
        repeat (HS_LEN) tick();
        vif.vid_sync = 1'b1;
        for (int m = 1; m <= LINE_T; m++) begin
            if (m == cut) return;
            vif.vid_data = dot_val(l, m);
            tick();
        end
    endtask

    task automatic send_vsync(input int len);
        vif.vid_sync = 1'b0;
        repeat (len) tick();
        vif.vid_sync = 1'b1;
        vif.vid_data = 1'b0;
        repeat (20) tick();
    endtask

    task automatic send_frame();
        send_vsync(VS_LEN);
        for (int s = 0; s < V_BACK - 1; s++) send_line(-1, 0);
        for (int l = 0; l < V_LINES; l++) send_line(l, 0);
        repeat (20) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        vif.vid_sync = 1'b1;
        vif.vid_data = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_we"},    32'(vif.fb_we), 0);
        chk({tag, "_addr"},  32'(vif.fb_addr), 0);
        chk({tag, "_data"},  32'(vif.fb_data), 0);
        chk({tag, "_line"},  32'(vif.line_no), 0);
        chk({tag, "_done"},  32'(vif.frame_done), 0);
        chk({tag, "_eshort"}, 32'(vif.err_short), 0);
        chk({tag, "_eframe"}, 32'(vif.err_frame), 0);
    endtask

    task automatic check_frame(input string tag, input int w0, input int f0);
        chk({tag, "_nwr"}, 32'(wa.size() - w0), 32'(V_LINES * H_BYTES));
        for (int i = 0; i < V_LINES * H_BYTES && w0 + i < wa.size(); i++) begin
            chk({tag, "_addr"}, 32'(wa[w0 + i]), 32'(i));
            chk({tag, "_data"}, 32'(wd[w0 + i]), 32'(exp_byte(i / H_BYTES, i % H_BYTES)));
        end
        chk({tag, "_fdone"}, 32'(fd_cnt - f0), 1);
        chk({tag, "_eshort"}, 32'(vif.err_short), 0);
        chk({tag, "_eframe"}, 32'(vif.err_frame), 0);
        chk({tag, "_line"}, 32'(vif.line_no), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, f0;
        vif.vid_sync = 1'b1;
        vif.vid_data = 1'b0;

        // reset state
        do_reset();
        check_outputs_zero("rst");

        // synthetic frame, then en=0 honoured in WAIT_VS
        en = 1'b1;
        w0 = wa.size(); f0 = fd_cnt;
        send_frame();
        check_frame("frame", w0, f0);
        en = 1'b0;
        w0 = wa.size();
        send_frame();
        chk("en_off_nwr", 32'(wa.size() - w0), 0);

        // classifier boundary: VS_MIN-1 is hsync (ignored in WAIT_VS), VS_MIN is vsync
        do_reset();
        en = 1'b1;
        w0 = wa.size();
        send_vsync(VS_MIN - 1);
        for (int s = 0; s < V_BACK; s++) send_line(0, 0);
        repeat (10) tick();
        chk("cls_short_nwr", 32'(wa.size() - w0), 0);
        send_vsync(VS_MIN);
        for (int s = 0; s < V_BACK - 1; s++) send_line(-1, 0);
        send_line(0, 0);
        repeat (10) tick();
        chk("cls_vs_nwr", 32'(wa.size() - w0), 32'(H_BYTES));
        if (wa.size() > w0) chk("cls_vs_addr", 32'(wa[w0]), 0);
        chk("cls_eframe", 32'(vif.err_frame), 0);

        // short line: sync falls in byte 2 of line 1
        do_reset();
        en = 1'b1;
        w0 = wa.size();
        send_vsync(VS_LEN);
        for (int s = 0; s < V_BACK - 1; s++) send_line(-1, 0);
        send_line(0, 0);
        send_line(1, 2 + H_BACK + 2 * 8 * DOT_DIV + 4 * DOT_DIV);
        send_line(2, 0);
        repeat (10) tick();
        chk("short_eshort", 32'(vif.err_short), 1);
        chk("short_nwr", 32'(wa.size() - w0), 10);
        if (wa.size() >= w0 + 10) begin
            chk("short_last_l1", 32'(wa[w0 + 5]), 5);
            chk("short_l2_addr", 32'(wa[w0 + 6]), 8);
            chk("short_l2_data", 32'(wd[w0 + 6]), 32'hA5);
            chk("short_l2_b3", 32'(wd[w0 + 9]), 32'(exp_byte(2, 3)));
        end
        chk("short_line", 32'(vif.line_no), 3);
        chk("short_eframe", 32'(vif.err_frame), 0);

        // early vsync at line 3
        do_reset();
        en = 1'b1;
        f0 = fd_cnt;
        send_vsync(VS_LEN);
        for (int s = 0; s < V_BACK - 1; s++) send_line(-1, 0);
        for (int l = 0; l < 3; l++) send_line(l, 0);
        send_vsync(VS_LEN);
        chk("early_eframe", 32'(vif.err_frame), 1);
        chk("early_line", 32'(vif.line_no), 0);
        w0 = wa.size();
        for (int s = 0; s < V_BACK - 1; s++) send_line(-1, 0);
        send_line(0, 0);
        repeat (10) tick();
        chk("early_fdone", 32'(fd_cnt - f0), 0);
        chk("early_nwr", 32'(wa.size() - w0), 32'(H_BYTES));
        if (wa.size() > w0) chk("early_addr", 32'(wa[w0]), 0);
        chk("early_eshort", 32'(vif.err_short), 0);

        // reset mid-CAPTURE, then clean recapture
        do_reset();
        en = 1'b1;
        send_vsync(VS_LEN);
        for (int s = 0; s < V_BACK - 1; s++) send_line(-1, 0);
        send_line(0, 0);
        send_line(1, 50);
        chk("mid_line_pre", 32'(vif.line_no), 1);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
        check_outputs_zero("midrst");
        w0 = wa.size();
        send_frame();
        chk("midrst_idle_nwr", 32'(wa.size() - w0), 0);
        en = 1'b1;
        w0 = wa.size(); f0 = fd_cnt;
        send_frame();
        check_frame("recap", w0, f0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
